// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares a single read port of the encrypted-image ROM between the display
// fetcher and the decrypter. Once the decrypter reports completion, the ROM
// contents are streamed out word by word through a copy-back write port,
// after which only the display keeps access to the ROM.
//
// Optional feature macro: ARB_STARVE_GUARD_EN
//   defined     -> after MAX_WAIT contended denials the decrypter is granted once
//   not defined -> display always wins contention
//
// Ports:
//   clk, rst             single clock, asynchronous active-high reset
//   disp_req, disp_addr  display fetch request and read address
//   dec_req, dec_addr    decrypter fetch request and read address
//   dec_done             decrypter finished (level), starts copy-back
//   mem_addr             registered ROM address
//   mem_dout             ROM data, valid the cycle after mem_addr
//   dec_gnt              decrypter address accepted (high the cycle after the grant edge)
//   disp_valid           rd_data belongs to the display this cycle
//   dec_valid            rd_data belongs to the decrypter this cycle
//   rd_data              combinational copy of mem_dout
//   cp_we, cp_addr       copy-back write enable and write address
//   cp_data              copy-back write data (= mem_dout)
//   cp_busy, cp_done     copy-back in progress / complete (sticky until reset)

module mem_port_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DEPTH    = 32768,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic              dec_req,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic              dec_done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_dout,
    output logic              dec_gnt,
    output logic              disp_valid,
    output logic              dec_valid,
    output logic [7:0]        rd_data,
    output logic              cp_we,
    output logic [ADDR_W-1:0] cp_addr,
    output logic [7:0]        cp_data,
    output logic              cp_busy,
    output logic              cp_done
);

    typedef enum logic [1:0] {ARB, COPY, FLUSH, DONE} state_e;

    // One extra bit so that DEPTH = 2^ADDR_W is reachable without wrapping.
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    state_e          state;
    state_e          next_state;
    logic [ADDR_W:0] cp_cnt;
    logic            disp_pend;
    logic            grant_disp;
    logic            grant_dec;
    logic            start_copy;
    logic            copy_issue;
    logic            force_dec;

`ifdef ARB_STARVE_GUARD_EN
    logic [7:0] starve_cnt;

    assign force_dec = (starve_cnt == 8'(MAX_WAIT));

    // Counts contended ARB cycles since the decrypter was last granted.
    // It cannot pass MAX_WAIT because reaching it forces a decrypter grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_dec) begin
            starve_cnt <= '0;
        end else if (state == ARB && !dec_done && disp_req && dec_req) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    assign force_dec = 1'b0;
`endif

    // ROM data goes straight through to both consumers.
    assign rd_data = mem_dout;
    assign cp_data = mem_dout;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. DONE only leaves through reset.
    always_comb begin
        next_state = state;
        case (state)
            ARB:     if (dec_done) next_state = COPY;
            COPY:    if (cp_cnt == DEPTH_CNT) next_state = FLUSH;
            FLUSH:   next_state = DONE;
            DONE:    next_state = DONE;
            default: next_state = ARB;
        endcase
    end

    // Output / control decode. dec_done in ARB takes precedence over both
    // requesters so the copy starts without issuing a grant on that edge.
    always_comb begin
        grant_disp = 1'b0;
        grant_dec  = 1'b0;
        start_copy = 1'b0;
        copy_issue = 1'b0;
        cp_busy    = 1'b0;
        cp_done    = 1'b0;
        case (state)
            ARB: begin
                if (dec_done) begin
                    start_copy = 1'b1;
                end else if (dec_req && (!disp_req || force_dec)) begin
                    grant_dec = 1'b1;
                end else if (disp_req) begin
                    grant_disp = 1'b1;
                end
            end
            COPY: begin
                cp_busy    = 1'b1;
                copy_issue = (cp_cnt != DEPTH_CNT);
            end
            FLUSH: begin
                cp_busy = 1'b1;
            end
            DONE: begin
                cp_done    = 1'b1;
                grant_disp = disp_req;
            end
            default: begin
                cp_busy = 1'b0;
            end
        endcase
    end

    // Datapath. Address 0 is issued on the edge that enters COPY, so the
    // first COPY cycle carries no write; every COPY edge then writes the
    // address issued one cycle before, whose data is on mem_dout next cycle.
    // Valids trail the grant by two edges to match the ROM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr   <= '0;
            dec_gnt    <= 1'b0;
            disp_pend  <= 1'b0;
            disp_valid <= 1'b0;
            dec_valid  <= 1'b0;
            cp_we      <= 1'b0;
            cp_addr    <= '0;
            cp_cnt     <= '0;
        end else begin
            disp_pend  <= grant_disp;
            dec_gnt    <= grant_dec;
            disp_valid <= disp_pend;
            dec_valid  <= dec_gnt;
            cp_we      <= (state == COPY);
            if (state == COPY) begin
                cp_addr <= mem_addr;
            end
            if (grant_disp) begin
                mem_addr <= disp_addr;
            end else if (grant_dec) begin
                mem_addr <= dec_addr;
            end else if (start_copy) begin
                mem_addr <= '0;
                cp_cnt   <= (ADDR_W+1)'(1);
            end else if (copy_issue) begin
                mem_addr <= cp_cnt[ADDR_W-1:0];
                cp_cnt   <= cp_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Drives mem_port_arbiter (ADDR_W=8, DEPTH=16, MAX_WAIT=8) against a ROM
// model holding data = addr ^ 8'hA5. Every read grant pushes its owner,
// data and due cycle to a scoreboard that a negedge monitor pops.

module tb_mem_port_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DEPTH    = 16;
    localparam int MAX_WAIT = 8;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              dec_req;
    logic [ADDR_W-1:0] dec_addr;
    logic              dec_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_dout;
    logic              dec_gnt;
    logic              disp_valid;
    logic              dec_valid;
    logic [7:0]        rd_data;
    logic              cp_we;
    logic [ADDR_W-1:0] cp_addr;
    logic [7:0]        cp_data;
    logic              cp_busy;
    logic              cp_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // owner: 1 = display, 2 = decrypter
    typedef struct {
        logic [1:0] owner;
        logic [7:0] data;
        int         due;
    } sb_t;

    sb_t sb[$];

    typedef struct {
        logic       disp_req;
        logic [7:0] disp_addr;
        logic       dec_req;
        logic [7:0] dec_addr;
        logic [1:0] owner;
        logic [7:0] exp_addr;
    } vec_t;

    vec_t vecs[10];

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .dec_req   (dec_req),
        .dec_addr  (dec_addr),
        .dec_done  (dec_done),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .dec_gnt   (dec_gnt),
        .disp_valid(disp_valid),
        .dec_valid (dec_valid),
        .rd_data   (rd_data),
        .cp_we     (cp_we),
        .cp_addr   (cp_addr),
        .cp_data   (cp_data),
        .cp_busy   (cp_busy),
        .cp_done   (cp_done)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter used to timestamp scoreboard entries.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: data appears the cycle after the address.
    always @(posedge clk) mem_dout <= mem_addr ^ 8'hA5;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Called just after a negedge: drive inputs, record any expected read,
    // then advance to the next negedge where outputs are stable.
    task automatic applyStimulus(input logic dr, input logic [7:0] da,
                                 input logic qr, input logic [7:0] qa,
                                 input logic dd, input logic [1:0] owner);
        sb_t e;
        disp_req  = dr;
        disp_addr = da;
        dec_req   = qr;
        dec_addr  = qa;
        dec_done  = dd;
        if (owner != 2'd0) begin
            e.owner = owner;
            e.data  = ((owner == 2'd1) ? da : qa) ^ 8'hA5;
            e.due   = cyc + 2;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Read-return monitor: every valid must match the oldest expected read
    // in owner, data and cycle; an overdue expected read is a miss.
    always @(negedge clk) begin
        sb_t e;
        if (!rst) begin
            if (disp_valid && dec_valid) begin
                checkOutput("both_valid", 32'({dec_valid, disp_valid}), 32'b01);
            end
            if (disp_valid || dec_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("valid_when_idle", 32'({dec_valid, disp_valid}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("valid_owner", 32'({dec_valid, disp_valid}),
                                (e.owner == 2'd1) ? 32'b01 : 32'b10);
                    checkOutput("rd_data", 32'(rd_data), 32'(e.data));
                    checkOutput("valid_latency", 32'(cyc), 32'(e.due));
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checkOutput("missing_valid", 32'(disp_valid | dec_valid), 32'd1);
            end
        end
    end

    // Absolute bound on the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  idx;
        bit  seen_done;
        bit  found;
        logic [1:0] own;

        vecs[0] = '{1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 8'h00};
        vecs[1] = '{1'b1, 8'h12, 1'b0, 8'h34, 2'd1, 8'h12};
        vecs[2] = '{1'b0, 8'h12, 1'b1, 8'h34, 2'd2, 8'h34};
        vecs[3] = '{1'b1, 8'h55, 1'b1, 8'h66, 2'd1, 8'h55};
        vecs[4] = '{1'b1, 8'h00, 1'b1, 8'h77, 2'd1, 8'h00};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 8'hFF, 2'd2, 8'hFF};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 8'hFF};
        vecs[7] = '{1'b1, 8'hAA, 1'b0, 8'h00, 2'd1, 8'hAA};
        vecs[8] = '{1'b1, 8'hAB, 1'b0, 8'h00, 2'd1, 8'hAB};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 8'h01, 2'd2, 8'h01};

        rst       = 1'b0;
        disp_req  = 1'b0;
        disp_addr = '0;
        dec_req   = 1'b0;
        dec_addr  = '0;
        dec_done  = 1'b0;
        #1 rst = 1'b1;
        #2;
        checkOutput("reset_outputs",
                    32'({mem_addr, cp_addr, dec_gnt, disp_valid, dec_valid, cp_we, cp_busy, cp_done}),
                    32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Arbitration table.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].disp_req, vecs[i].disp_addr, vecs[i].dec_req,
                          vecs[i].dec_addr, 1'b0, vecs[i].owner);
            checkOutput("tbl_dec_gnt", 32'(dec_gnt), 32'(vecs[i].owner == 2'd2));
            checkOutput("tbl_mem_addr", 32'(mem_addr), 32'(vecs[i].exp_addr));
        end

        // 20 cycles of continuous contention.
        for (int k = 1; k <= 20; k++) begin
            own = (GUARD && (k == 9 || k == 18)) ? 2'd2 : 2'd1;
            applyStimulus(1'b1, 8'(8'h20 + k), 1'b1, 8'(8'h80 + k), 1'b0, own);
            checkOutput("contend_dec_gnt", 32'(dec_gnt), 32'(own == 2'd2));
        end
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0);

        // Copy-back with both requesters active: they must be ignored.
        applyStimulus(1'b1, 8'h3C, 1'b1, 8'hC3, 1'b1, 2'd0);
        checkOutput("copy_entry_no_gnt", 32'(dec_gnt), 32'd0);
        checkOutput("copy_first_cycle", 32'({cp_busy, cp_we, cp_done}), 32'b100);
        checkOutput("copy_first_addr", 32'(mem_addr), 32'd0);
        dec_done  = 1'b0;
        idx       = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            @(negedge clk);
            if (cp_done) begin
                seen_done = 1'b1;
                disp_req  = 1'b0;
            end else if (cp_we) begin
                checkOutput("cp_addr", 32'(cp_addr), 32'(idx));
                checkOutput("cp_data", 32'(cp_data), 32'(idx[7:0] ^ 8'hA5));
                idx++;
            end
        end
        checkOutput("cp_done_seen", 32'(seen_done), 32'd1);
        checkOutput("cp_write_count", 32'(idx), 32'(DEPTH));
        checkOutput("done_flags", 32'({cp_we, cp_busy, cp_done}), 32'b001);

        // DONE: display served, decrypter ignored even with dec_done high.
        for (int k = 0; k < 6; k++) begin
            own = (k % 2 == 1) ? 2'd1 : 2'd0;
            applyStimulus(own[0], 8'(8'h40 + k), 1'b1, 8'h90, 1'b1, own);
            checkOutput("done_dec_gnt", 32'(dec_gnt), 32'd0);
            checkOutput("done_sticky", 32'({cp_we, cp_busy, cp_done}), 32'b001);
        end
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0);

        // Reset out of DONE, restart the copy, then abort it at address 7.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_clears_done", 32'(cp_done), 32'd0);
        dec_done = 1'b1;
        @(negedge clk);
        dec_done = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (cp_we && cp_addr == 8'd7) found = 1'b1;
        end
        checkOutput("reach_copy_addr7", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1 checkOutput("async_rst_copy", 32'({cp_we, cp_busy}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checkOutput("post_abort_idle", 32'({cp_we, cp_busy, cp_done}), 32'd0);
        end
        checkOutput("post_abort_addr", 32'(mem_addr), 32'd0);

        // A plain read after the abort proves the machine is back in ARB.
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 2'd2);
        checkOutput("post_abort_dec_gnt", 32'(dec_gnt), 32'd1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
